// File: rtl/sm_stim_seq.sv
// sm_stim_seq: replays a {i1,i2} pattern into an FSM and compacts {o1,o2,err} into a MISR plus err count
// Optional SM_STIM_ERR_STOP_EN ends the run on the first sampled err
module sm_stim_seq #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int LAT = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             pat_we,
  input  logic [AW-1:0]    pat_addr,
  input  logic [1:0]       pat_wdata,
  input  logic [AW:0]      len,
  input  logic             start,
  output logic             i1,
  output logic             i2,
  input  logic             o1,
  input  logic             o2,
  input  logic             err,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      sig
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [LAT:0] TOP = (LAT+1)'(1) << LAT;
  state_t state, state_nx;
  logic [1:0] pat [DEPTH];
  logic [AW:0] idx, eff_len;
  logic [LAT:0] vp;
  logic go, drive, smp, fin, stop;
  always_comb begin
    eff_len = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    go = state == IDLE && start && len != '0;
    drive = state == RUN && idx < eff_len;
    smp = vp[LAT];
    // the final sample is the last valid in the pipe once nothing new is driven
    fin = smp && (vp & ~TOP) == '0 && (state == DRAIN || (state == RUN && !drive));
`ifdef SM_STIM_ERR_STOP_EN
    stop = smp && err;
`else
    stop = 1'b0;
`endif
    state_nx = go ? RUN : (fin || stop) ? IDLE : (state == RUN && !drive) ? DRAIN : state;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < DEPTH; k++) pat[k] <= 2'b00;
      {i1, i2} <= 2'b00;
      idx <= '0;
      vp <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_cnt <= '0;
      sig <= 16'hFFFF;
    end else begin
      if (state == IDLE && pat_we) pat[pat_addr] <= pat_wdata;
      {i1, i2} <= go ? pat[0] : (drive && !stop) ? pat[idx[AW-1:0]] : 2'b00;
      idx <= go ? (AW+1)'(1) : drive ? idx + (AW+1)'(1) : idx;
      vp <= stop ? '0 : (vp << 1) | (LAT+1)'(go || drive);
      busy <= go ? 1'b1 : (fin || stop) ? 1'b0 : busy;
      done <= fin || stop;
      if (go) begin
        err_cnt <= '0;
        sig <= 16'hFFFF;
      end else if (smp) begin
        sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {13'b0, o1, o2, err};
        if (err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sm_stim_seq.sv
// tb_sm_stim_seq: directed runs against a registered stand-in FSM with a queue scoreboard
module tb_sm_stim_seq;
  localparam int DEPTH = 16, AW = 4, LAT = 1;
  logic clk = 1'b0, nrst = 1'b0, pat_we = 1'b0, start = 1'b0;
  logic [AW-1:0] pat_addr = '0;
  logic [1:0] pat_wdata = '0;
  logic [AW:0] len = '0;
  logic i1, i2, busy, done, o1 = 1'b0, o2 = 1'b0, err = 1'b0;
  logic [7:0] err_cnt;
  logic [15:0] sig;
  logic s_i1, s_i2, s_busy, s_done;
  logic [3:0] s_cnt;
  logic [15:0] s_sig;
  int npass = 0, ntotal = 0, emode = 0;
  logic [1:0] pat_m [DEPTH];
  logic [1:0] exp_i [$];
  logic [31:0] exp_res [$];

  sm_stim_seq #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata),
    .len(len), .start(start), .i1(i1), .i2(i2), .o1(o1), .o2(o2), .err(err),
    .busy(busy), .done(done), .err_cnt(err_cnt), .sig(sig));

  sm_stim_seq #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT), .CNT_W(4)) u_sat (
    .clk(clk), .nrst(nrst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata),
    .len(len), .start(start), .i1(s_i1), .i2(s_i2), .o1(o1), .o2(o2), .err(err),
    .busy(s_busy), .done(s_done), .err_cnt(s_cnt), .sig(s_sig));

  always #5 clk = ~clk;

  function automatic logic [2:0] resp(input logic [1:0] p);
    return {p[1] ^ p[0], p[1], emode == 1 ? 1'b1 : emode == 2 ? (p[1] & p[0]) : 1'b0};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [2:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, r};
  endfunction

  // stand-in FSM with one register of output latency
  always @(posedge clk) {o1, o2, err} <= resp({i1, i2});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic prog(input int a, input logic [1:0] d);
    @(negedge clk);
    pat_we = 1'b1; pat_addr = AW'(a); pat_wdata = d;
    @(posedge clk); #1;
    pat_we = 1'b0;
    pat_m[a] = d;
  endtask

  task automatic run(input int l, input int em, input int stop_k, input bit wr);
    int le, de, j, bc, c;
    bit seen;
    logic [15:0] s;
    logic [2:0] r;
    logic [31:0] res;
    emode = em;
    le = l > DEPTH ? DEPTH : l;
    de = stop_k >= 0 ? stop_k + LAT + 1 : le + LAT;
    s = 16'hFFFF; c = 0;
    for (int k = 0; k < le && (stop_k < 0 || k <= stop_k); k++) begin
      r = resp(pat_m[k]);
      s = misr(s, r);
      if (r[0]) c++;
    end
    for (int k = 0; k <= de; k++) exp_i.push_back((k < le && k < de) ? pat_m[k] : 2'b00);
    exp_res.push_back({s, 4'(c > 15 ? 15 : c), 4'(0), 8'(c)});
    @(negedge clk);
    len = (AW+1)'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0; bc = 0; seen = 0;
    while (!seen && j < 300) begin
      if (exp_i.size() > 0) check("drive", {i1, i2}, exp_i.pop_front());
      if (busy) bc++;
      if (wr && j == 1) begin
        pat_we = 1'b1; pat_addr = '0; pat_wdata = ~pat_m[0];
      end else pat_we = 1'b0;
      if (done) begin
        seen = 1;
        res = exp_res.pop_front();
        check("done_edge", j, de);
        check("busy_cycles", bc, de);
        check("sig", sig, res[31:16]);
        check("err_cnt", err_cnt, res[7:0]);
        check("err_cnt_sat", s_cnt, res[15:12]);
      end else begin
        @(posedge clk); #1;
        j++;
      end
    end
    pat_we = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    exp_i.delete();
    exp_res.delete();
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int dc;
    for (int k = 0; k < DEPTH; k++) pat_m[k] = 2'b00;
    #12;
    check("rst_i", {i1, i2}, 0);
    check("rst_sig", sig, 16'hFFFF);
    check("rst_cnt", err_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); nrst = 1'b1;
    run(1, 0, -1, 0);
    check("zero_sig", sig, 16'hEFDF);
    prog(0, 2'b11); prog(1, 2'b01); prog(2, 2'b10); prog(3, 2'b00);
    run(4, 0, -1, 0);
    for (int k = 0; k < DEPTH; k++) prog(k, 2'($urandom_range(3)));
    run(16, 1, -1, 0);
    check("err16", err_cnt, 16);
    check("err_sat15", s_cnt, 15);
    run(31, 0, -1, 0);
    @(negedge clk); len = '0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("len0_busy", busy, 0);
    check("len0_i", {i1, i2}, 0);
    check("len0_done", done, 0);
    start = 1'b0;
    run(4, 0, -1, 1);
    run(4, 0, -1, 0);
    prog(0, 2'b00); prog(1, 2'b01); prog(2, 2'b11); prog(3, 2'b10);
`ifdef SM_STIM_ERR_STOP_EN
    run(4, 2, 2, 0);
`else
    run(4, 2, -1, 0);
`endif
    check("one_err", err_cnt, 1);
    prog(3, 2'b11);
    @(negedge clk); len = 5'd8; start = 1'b1; emode = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_i_live", {i1, i2}, 2'b11);
    nrst = 1'b0;
    #1;
    check("mid_rst_i", {i1, i2}, 0);
    check("mid_rst_sig", sig, 16'hFFFF);
    check("mid_rst_cnt", err_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk); nrst = 1'b1;
    dc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    check("mid_no_done", dc, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
